// File: rtl/wb_slave_responder.sv
// wb_slave_responder: Wishbone classic-cycle slave with a 4-entry register bank
// (CTRL, DATA, CMD, STAT), a programmable wait-state count and a level interrupt
// raised by accepted commands.
// Optional feature: define WB_RESP_ERR_EN to add the err_o port. Writes to STAT
// are then answered with err_o instead of ack_o.
module wb_slave_responder #(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  irq_o
`ifdef WB_RESP_ERR_EN
  ,
  output logic                  err_o
`endif
);

`ifdef WB_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_CMD  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;
  localparam logic [3:0] WS_LOAD  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] wcnt;
  logic [3:0] wcnt_next;
  logic       capture;
  logic       commit;

  // Latched transfer request
  logic       we_q;
  logic [1:0] adr_q;
  logic [7:0] dat_q;

  // Register bank
  logic [7:0] ctrl;
  logic [7:0] data;
  logic [7:0] cmd;
  logic [7:0] stat;
  logic [7:0] rd_val;
  logic       err_q;
  logic       resp_busy;
  logic       stat_wr;

  // The response cycle still carries the master's strobe for the finished
  // transfer, so it must not be taken as a new request.
  assign resp_busy = ack_o | err_q;
  assign stat_wr   = we_q && (adr_q == REG_STAT);

`ifdef WB_RESP_ERR_EN
  assign err_o = err_q;
`endif

  // State register and wait counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= next_state;
      wcnt  <= wcnt_next;
    end
  end

  // Next-state logic: accept a request, count wait states, abort on strobe loss.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    next_state = state;
    wcnt_next  = wcnt;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cyc_i && stb_i && !resp_busy) begin
          capture    = 1'b1;
          wcnt_next  = WS_LOAD;
          next_state = (WS_LOAD != 4'd0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!(cyc_i && stb_i)) begin
          next_state = ST_IDLE;
        end else if (wcnt <= 4'd1) begin
          next_state = ST_ACK;
        end else begin
          wcnt_next = wcnt - 4'd1;
        end
      end
      ST_ACK: begin
        commit     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Capture address, direction and write data when a request is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q  <= 1'b0;
      adr_q <= 2'd0;
      dat_q <= 8'd0;
    end else if (capture) begin
      we_q  <= we_i;
      adr_q <= adr_i[1:0];
      dat_q <= dat_i[7:0];
    end
  end

  // Read multiplexer over the latched address; STAT[5:4] are always zero.
  always_comb begin
    rd_val = 8'd0;
    case (adr_q)
      REG_CTRL: rd_val = ctrl;
      REG_DATA: rd_val = data;
      REG_CMD:  rd_val = cmd;
      REG_STAT: rd_val = {stat[7:6], 2'b00, stat[3:0]};
      default:  rd_val = 8'd0;
    endcase
  end

  // Register bank, read data, interrupt and response pulses; all effects land
  // on the edge that leaves ST_ACK.
  // NOTE: the register bank is a handful of flops, not a RAM, so it is reset
  // along with the rest of the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl  <= 8'd0;
      data  <= 8'd0;
      cmd   <= 8'd0;
      stat  <= 8'd0;
      irq_o <= 1'b0;
      dat_o <= '0;
      ack_o <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_q <= 1'b0;
      if (!ctrl[6]) begin
        irq_o <= 1'b0;
      end
      if (commit) begin
        if (ERR_EN && stat_wr) begin
          err_q <= 1'b1;
        end else begin
          ack_o <= 1'b1;
        end
        if (we_q) begin
          case (adr_q)
            REG_CTRL: ctrl <= dat_q;
            REG_DATA: data <= dat_q;
            REG_CMD: begin
              if (ctrl[7]) begin
                cmd       <= dat_q;
                stat[3:0] <= stat[3:0] + 4'd1;
                stat[7]   <= 1'b1;
                if (ctrl[6]) begin
                  irq_o <= 1'b1;
                end
              end else begin
                stat[6] <= 1'b1;
              end
            end
            default: ;  // STAT is read-only
          endcase
        end else begin
          dat_o <= DATA_WIDTH'(rd_val);
          if (adr_q == REG_STAT) begin
            stat[7:6] <= 2'b00;
            irq_o     <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_responder.sv
// Bench for wb_slave_responder: three instances (WAIT_STATES 0, 1, 3), each on
// its own bus, driven by a master task. A register-level model tracks what each
// responder must present; a compare process checks every output each cycle.
module tb_wb_slave_responder;

`ifdef WB_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cyc[3];
  logic       stb[3];
  logic       we[3];
  logic [1:0] adr[3];
  logic [7:0] wdat[3];
  logic [7:0] rdat[3];
  logic       ack[3];
  logic       irq[3];
  logic       err[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    wb_slave_responder #(
      .ADDR_WIDTH (2),
      .DATA_WIDTH (8),
      .WAIT_STATES(WS)
    ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .cyc_i(cyc[g]),
      .stb_i(stb[g]),
      .we_i (we[g]),
      .adr_i(adr[g]),
      .dat_i(wdat[g]),
      .dat_o(rdat[g]),
      .ack_o(ack[g]),
      .irq_o(irq[g])
`ifdef WB_RESP_ERR_EN
      ,
      .err_o(err[g])
`endif
    );
`ifndef WB_RESP_ERR_EN
    assign err[g] = 1'b0;
`endif
  end

  // Bookkeeping
  int n_err = 0;
  int n_chk = 0;
  int cyc_n = 0;
  bit run_cmp = 1'b0;

  // Register-level model per instance
  logic [7:0] m_ctrl[3];
  logic [7:0] m_data[3];
  logic [7:0] m_cmd[3];
  int         m_cnt[3];
  bit         m_done[3];
  bit         m_rej[3];
  bit         m_irq[3];
  bit         m_pend[3];
  logic [7:0] m_rd[3];
  bit         m_errx[3];
  int         ack_edge[3];

  always @(posedge clk) cyc_n = cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic logic [7:0] m_stat(input int i);
    return {m_done[i], m_rej[i], 2'b00, 4'(m_cnt[i] % 16)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ctrl[i]   = 8'h00;
      m_data[i]   = 8'h00;
      m_cmd[i]    = 8'h00;
      m_cnt[i]    = 0;
      m_done[i]   = 1'b0;
      m_rej[i]    = 1'b0;
      m_irq[i]    = 1'b0;
      m_pend[i]   = 1'b0;
      m_rd[i]     = 8'h00;
      m_errx[i]   = 1'b0;
      ack_edge[i] = -1;
    end
  endtask

  // Effect of one completed transfer on the register-level view.
  task automatic model_apply(input int i, input logic w, input logic [1:0] a, input logic [7:0] d);
    if (!w) begin
      case (a)
        2'd0:    m_rd[i] = m_ctrl[i];
        2'd1:    m_rd[i] = m_data[i];
        2'd2:    m_rd[i] = m_cmd[i];
        default: begin
          m_rd[i]   = m_stat(i);
          m_done[i] = 1'b0;
          m_rej[i]  = 1'b0;
          m_irq[i]  = 1'b0;
        end
      endcase
    end else begin
      case (a)
        2'd0: begin
          m_ctrl[i] = d;
          if (!d[6]) m_pend[i] = m_irq[i];
        end
        2'd1: m_data[i] = d;
        2'd2: begin
          if (m_ctrl[i][7]) begin
            m_cmd[i]  = d;
            m_cnt[i]  = m_cnt[i] + 1;
            m_done[i] = 1'b1;
            if (m_ctrl[i][6]) m_irq[i] = 1'b1;
          end else begin
            m_rej[i] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic bus_idle(input int i);
    cyc[i]  = 1'b0;
    stb[i]  = 1'b0;
    we[i]   = 1'b0;
    adr[i]  = 2'd0;
    wdat[i] = 8'h00;
  endtask

  // One master transfer. lat = cycles from the sampling edge to the observed
  // response (-1 if none), rd = dat_o seen with the response.
  task automatic xfer(input int i, input logic w, input logic [1:0] a, input logic [7:0] d,
                      input bit abort, output int lat, output logic [7:0] rd);
    int ws;
    ws  = ws_of(i);
    lat = -1;
    rd  = 8'h00;
    @(negedge clk);
    cyc[i]  = 1'b1;
    stb[i]  = 1'b1;
    we[i]   = w;
    adr[i]  = a;
    wdat[i] = d;
    @(posedge clk);
    #1;
    if (!abort) begin
      ack_edge[i] = cyc_n + ws + 1;
      m_errx[i]   = ERR_EN && w && (a == 2'd3);
    end else begin
      @(negedge clk);
      bus_idle(i);
    end
    for (int k = 1; k <= ws + 1; k++) begin
      @(posedge clk);
      #1;
      if (!abort && k == ws + 1) model_apply(i, w, a, d);
      @(negedge clk);
      if ((ack[i] === 1'b1 || err[i] === 1'b1) && lat < 0) begin
        lat = k;
        rd  = rdat[i];
      end
    end
    bus_idle(i);
    @(posedge clk);
    #1;
    if (m_pend[i]) begin
      m_irq[i]  = 1'b0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Compare every output of every instance against the model each cycle.
  always @(negedge clk) begin
    if (run_cmp) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("ack_o[%0d]", i), ack[i], (cyc_n == ack_edge[i]) && !m_errx[i]);
        check($sformatf("err_o[%0d]", i), err[i], (cyc_n == ack_edge[i]) && m_errx[i]);
        check($sformatf("irq_o[%0d]", i), irq[i], m_irq[i]);
        check($sformatf("dat_o[%0d]", i), rdat[i], m_rd[i]);
      end
    end
  end

  initial begin
    int         lat;
    logic [7:0] rd;
    int         exp_lat[3] = '{1, 2, 4};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) bus_idle(i);
    model_reset();
    run_cmp = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ack[%0d]", i), ack[i], 1'b0);
      check($sformatf("reset_irq[%0d]", i), irq[i], 1'b0);
      check($sformatf("reset_dat[%0d]", i), rdat[i], 8'h00);
    end
    rst = 1'b0;

    // Reset in the middle of a WAIT_STATES=3 transfer
    xfer(2, 1'b1, 2'd1, 8'h11, 1'b0, lat, rd);
    xfer(2, 1'b1, 2'd0, 8'h3F, 1'b0, lat, rd);
    @(negedge clk);
    cyc[2]  = 1'b1;
    stb[2]  = 1'b1;
    we[2]   = 1'b1;
    adr[2]  = 2'd1;
    wdat[2] = 8'h22;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    bus_idle(2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      xfer(2, 1'b0, 2'(a), 8'h00, 1'b0, lat, rd);
      check($sformatf("post_reset_rd[%0d]", a), rd, 8'h00);
    end

    // Latency per wait-state setting, DATA round trip
    for (int i = 0; i < 3; i++) begin
      xfer(i, 1'b1, 2'd1, 8'hA5, 1'b0, lat, rd);
      check($sformatf("wr_latency[%0d]", i), lat, exp_lat[i]);
      xfer(i, 1'b0, 2'd1, 8'h00, 1'b0, lat, rd);
      check($sformatf("rd_latency[%0d]", i), lat, exp_lat[i]);
      check($sformatf("rd_data[%0d]", i), rd, 8'hA5);
    end

    // Strobe dropped during WAIT: no response, DATA unchanged
    xfer(2, 1'b1, 2'd1, 8'h3C, 1'b1, lat, rd);
    check("abort_no_ack", lat, -1);
    xfer(2, 1'b0, 2'd1, 8'h00, 1'b0, lat, rd);
    check("abort_data_kept", rd, 8'hA5);

    // Command rejected while disabled
    xfer(1, 1'b1, 2'd2, 8'h04, 1'b0, lat, rd);
    check("rej_irq", irq[1], 1'b0);
    xfer(1, 1'b0, 2'd2, 8'h00, 1'b0, lat, rd);
    check("rej_cmd", rd, 8'h00);
    xfer(1, 1'b0, 2'd3, 8'h00, 1'b0, lat, rd);
    check("rej_stat", rd, 8'h40);
    xfer(1, 1'b0, 2'd3, 8'h00, 1'b0, lat, rd);
    check("rej_stat_cleared", rd, 8'h00);

    // 17 accepted commands with interrupts enabled
    xfer(0, 1'b1, 2'd0, 8'hC0, 1'b0, lat, rd);
    for (int k = 0; k < 17; k++) xfer(0, 1'b1, 2'd2, 8'(k), 1'b0, lat, rd);
    check("cmd_irq_set", irq[0], 1'b1);
    check("model_stat_0x81", m_stat(0), 8'h81);
    xfer(0, 1'b0, 2'd3, 8'h00, 1'b0, lat, rd);
    check("stat_rd_0x81", rd, 8'h81);
    check("stat_rd_irq_clr", irq[0], 1'b0);
    xfer(0, 1'b0, 2'd3, 8'h00, 1'b0, lat, rd);
    check("stat_rd_0x01", rd, 8'h01);

    // Clearing irq_en drops the interrupt but keeps done
    xfer(0, 1'b1, 2'd2, 8'h5A, 1'b0, lat, rd);
    check("cmd18_irq", irq[0], 1'b1);
    xfer(0, 1'b1, 2'd0, 8'h80, 1'b0, lat, rd);
    check("irq_en_clr", irq[0], 1'b0);
    xfer(0, 1'b0, 2'd2, 8'h00, 1'b0, lat, rd);
    check("cmd_value", rd, 8'h5A);
    xfer(0, 1'b0, 2'd3, 8'h00, 1'b0, lat, rd);
    check("stat_rd_0x82", rd, 8'h82);

    // Write to read-only STAT
    xfer(0, 1'b1, 2'd3, 8'hFF, 1'b0, lat, rd);
    check("stat_wr_resp_latency", lat, 1);
    xfer(2, 1'b1, 2'd3, 8'hFF, 1'b0, lat, rd);
    check("stat_wr_resp_latency_ws3", lat, 4);
    xfer(0, 1'b0, 2'd3, 8'h00, 1'b0, lat, rd);
    check("stat_unchanged", rd, 8'h02);

    repeat (3) @(negedge clk);
    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
